// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port RAM between two femtorv bus masters
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic [31:0]       m0_rdata,
  output logic              m0_rbusy,
  output logic              m0_wbusy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
  output logic [31:0]       m1_rdata,
  output logic              m1_rbusy,
  output logic              m1_wbusy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata
);
  logic [1:0]        p_v, p_rd, req, cap;
  logic [ADDR_W-1:0] p_addr [2];
  logic [31:0]       p_wdata [2];
  logic [3:0]        p_wmask [2];
  logic [31:0]       hold [2];
  logic              last_loser, use_p, sel, gnt, rd_v, rd_own;
  // a pending slot always issues the very next cycle, so it doubles as the busy flag
  assign req[0] = (m0_rstrb | (|m0_wmask)) & ~p_v[0];
  assign req[1] = (m1_rstrb | (|m1_wmask)) & ~p_v[1];
  assign use_p  = |p_v;
  assign sel    = p_v[1] ? 1'b1 : p_v[0] ? 1'b0 : (&req) ? last_loser : req[1];
  assign gnt    = use_p | (|req);
  assign cap[0] = req[0] & (use_p | sel);
  assign cap[1] = req[1] & (use_p | ~sel);
  always_comb begin
    mem_addr  = use_p ? p_addr[sel] : sel ? m1_addr : m0_addr;
    mem_wdata = use_p ? p_wdata[sel] : sel ? m1_wdata : m0_wdata;
    mem_wmask = !gnt ? 4'b0 : use_p ? p_wmask[sel] : sel ? m1_wmask : m0_wmask;
    mem_rstrb = gnt & (use_p ? p_rd[sel] : sel ? m1_rstrb : m0_rstrb);
  end
  assign m0_rbusy = p_v[0] & p_rd[0];
  assign m1_rbusy = p_v[1] & p_rd[1];
  assign m0_wbusy = p_v[0] & (|p_wmask[0]);
  assign m1_wbusy = p_v[1] & (|p_wmask[1]);
  assign m0_rdata = (rd_v & ~rd_own) ? mem_rdata : hold[0];
  assign m1_rdata = (rd_v & rd_own) ? mem_rdata : hold[1];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_v        <= '0;
      p_rd       <= '0;
      p_addr     <= '{default: '0};
      p_wdata    <= '{default: '0};
      p_wmask    <= '{default: '0};
      hold       <= '{default: '0};
      last_loser <= 1'b0;
      rd_v       <= 1'b0;
      rd_own     <= 1'b0;
    end else begin
      p_v <= cap;
      if (cap[0]) begin
        p_addr[0]  <= m0_addr;
        p_wdata[0] <= m0_wdata;
        p_wmask[0] <= m0_wmask;
        p_rd[0]    <= m0_rstrb;
      end
      if (cap[1]) begin
        p_addr[1]  <= m1_addr;
        p_wdata[1] <= m1_wdata;
        p_wmask[1] <= m1_wmask;
        p_rd[1]    <= m1_rstrb;
      end
      if ((&req) & ~use_p) last_loser <= ~last_loser;
      rd_v <= mem_rstrb;
      if (mem_rstrb) rd_own <= sel;
      if (rd_v) hold[rd_own] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus reset/round-robin sequences against a behavioural RAM
module tb_mem_arbiter;
  logic        clk = 1'b0, resetn = 1'b0;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wmask, m1_wmask, mem_wmask;
  logic        m0_rstrb, m0_rbusy, m0_wbusy, m1_rstrb, m1_rbusy, m1_wbusy, mem_rstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram [64];
  int checks = 0, errors = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port RAM, 1-cycle read latency, read returns pre-write data
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[0]  <= 32'hA0A0A0A0;
      ram[1]  <= 32'hB1B1B1B1;
      ram[4]  <= 32'hDEADBEEF;
      ram[8]  <= 32'hCAFEF00D;
      ram[9]  <= 32'h99999999;
      ram[11] <= 32'h44444444;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic r0; logic [3:0] w0; logic [31:0] a0, d0;
    logic r1; logic [3:0] w1; logic [31:0] a1, d1;
    logic er; logic [3:0] ew; logic [31:0] ea, ed;
    logic [3:0] eb; logic [31:0] eq0, eq1;
  } vec_t;
  vec_t v [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] w0, input logic [31:0] a0, d0,
                       input logic r1, input logic [3:0] w1, input logic [31:0] a1, d1);
    m0_rstrb = r0; m0_wmask = w0; m0_addr = a0; m0_wdata = d0;
    m1_rstrb = r1; m1_wmask = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    drive(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    //        r0 w0    a0     d0            r1 w1    a1     d1            er ew    ea     ed            eb       eq0           eq1
    v[0]  = '{1, 4'h0, 32'h10, 32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h10, 32'h0,        4'b0000, 32'h0,        32'h0};
    v[1]  = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'h0};
    v[2]  = '{1, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h4,  32'h0,        1, 4'h0, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'h0};
    v[3]  = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h4,  32'h0,        4'b0100, 32'hA0A0A0A0, 32'h0};
    v[4]  = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        4'b0000, 32'hA0A0A0A0, 32'hB1B1B1B1};
    v[5]  = '{1, 4'h0, 32'h10, 32'h0,        1, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h0,  32'h0,        4'b0000, 32'hA0A0A0A0, 32'hB1B1B1B1};
    v[6]  = '{1, 4'h0, 32'h4,  32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h10, 32'h0,        4'b0001, 32'hA0A0A0A0, 32'hA0A0A0A0};
    v[7]  = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'hA0A0A0A0};
    v[8]  = '{0, 4'hF, 32'h24, 32'h11111111, 1, 4'h0, 32'h24, 32'h0,        0, 4'hF, 32'h24, 32'h11111111, 4'b0000, 32'hDEADBEEF, 32'hA0A0A0A0};
    v[9]  = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h24, 32'h0,        4'b0100, 32'hDEADBEEF, 32'hA0A0A0A0};
    v[10] = '{1, 4'h0, 32'h20, 32'h0,        0, 4'h3, 32'h20, 32'h12345678, 0, 4'h3, 32'h20, 32'h12345678, 4'b0000, 32'hDEADBEEF, 32'h11111111};
    v[11] = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h20, 32'h0,        4'b0001, 32'hDEADBEEF, 32'h11111111};
    v[12] = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        4'b0000, 32'hCAFE5678, 32'h11111111};
    v[13] = '{0, 4'hF, 32'h28, 32'h22222222, 0, 4'hC, 32'h2C, 32'h33330000, 0, 4'hF, 32'h28, 32'h22222222, 4'b0000, 32'hCAFE5678, 32'h11111111};
    v[14] = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 4'hC, 32'h2C, 32'h33330000, 4'b1000, 32'hCAFE5678, 32'h11111111};
    v[15] = '{1, 4'h0, 32'h28, 32'h0,        1, 4'h0, 32'h2C, 32'h0,        1, 4'h0, 32'h2C, 32'h0,        4'b0000, 32'hCAFE5678, 32'h11111111};
    v[16] = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        1, 4'h0, 32'h28, 32'h0,        4'b0001, 32'hCAFE5678, 32'h33334444};
    v[17] = '{0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        0, 4'h0, 32'h0,  32'h0,        4'b0000, 32'h22222222, 32'h33334444};

    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset mem_rstrb", {31'h0, mem_rstrb}, 32'h0);
    chk("reset mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("reset busy", {28'h0, m1_wbusy, m1_rbusy, m0_wbusy, m0_rbusy}, 32'h0);
    chk("reset m0_rdata", m0_rdata, 32'h0);
    chk("reset m1_rdata", m1_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
      #1;
      chk($sformatf("v%0d mem_rstrb", i), {31'h0, mem_rstrb}, {31'h0, v[i].er});
      chk($sformatf("v%0d mem_wmask", i), {28'h0, mem_wmask}, {28'h0, v[i].ew});
      chk($sformatf("v%0d mem_addr", i), mem_addr, v[i].ea);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].ed);
      chk($sformatf("v%0d busy", i), {28'h0, m1_wbusy, m1_rbusy, m0_wbusy, m0_rbusy}, {28'h0, v[i].eb});
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, v[i].eq0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, v[i].eq1);
    end

    // make m0 the loser, then pulse reset while its read is pending
    @(negedge clk);
    drive(1, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h4, 32'h0);
    #1 chk("seqA m0 wins addr", mem_addr, 32'h0);
    @(negedge clk);
    idle();
    #1 chk("seqB m1_rbusy", {31'h0, m1_rbusy}, 32'h1);
    @(negedge clk);
    #1 chk("seqC m1_rdata", m1_rdata, 32'hB1B1B1B1);
    @(negedge clk);
    drive(1, 4'h0, 32'h10, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    #1 chk("seqD m1 wins addr", mem_addr, 32'h0);
    @(negedge clk);
    idle();
    resetn = 1'b0;
    #1;
    chk("rst m0_rbusy", {31'h0, m0_rbusy}, 32'h0);
    chk("rst mem_rstrb", {31'h0, mem_rstrb}, 32'h0);
    chk("rst m0_rdata", m0_rdata, 32'h0);
    chk("rst m1_rdata", m1_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("post-rst no issue", {31'h0, mem_rstrb}, 32'h0);
    @(negedge clk);
    drive(1, 4'h0, 32'h4, 32'h0, 1, 4'h0, 32'h0, 32'h0);
    #1 chk("post-rst m0 wins", mem_addr, 32'h4);
    @(negedge clk);
    idle();
    #1;
    chk("post-rst m1_rbusy", {31'h0, m1_rbusy}, 32'h1);
    chk("post-rst m0_rdata", m0_rdata, 32'hB1B1B1B1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
